// File: rtl/fclass_pipe.sv
// rtl/fclass_pipe.sv - pipelined RISC-V FCLASS.S/FCLASS.D classifier with valid/ready and tag passthrough
module fclass_pipe #(
    parameter int FLEN        = 32,
    parameter int XLEN        = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [FLEN-1:0]  i_rs1_f,
    input  logic             i_fmt,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_rd,
    output logic [TAG_W-1:0] o_tag
);

    typedef struct packed {
        logic nan_box;
        logic sign;
        logic exp_max;
        logic exp_zero;
        logic man_zero;
        logic quiet;
    } dec_t;

    logic [63:0]      op;
    logic             is_d;
    dec_t             dec_in;
    logic [9:0]       cls_q;
    logic [TAG_W-1:0] tag_q;
    logic             adv_out;
    logic             accept;

    // A 32-bit register file has no upper half, so single operands are always validly boxed.
    generate
        if (FLEN == 64) begin : g_flen64
            assign op   = i_rs1_f;
            assign is_d = i_fmt;
        end else begin : g_flen32
            logic unused_fmt;
            assign unused_fmt = i_fmt;
            assign op         = {32'hFFFF_FFFF, i_rs1_f};
            assign is_d       = 1'b0;
        end
    endgenerate

    always_comb begin
        dec_in = '0;
        if (is_d) begin
            dec_in.sign     = op[63];
            dec_in.exp_max  = &op[62:52];
            dec_in.exp_zero = ~|op[62:52];
            dec_in.man_zero = ~|op[51:0];
            dec_in.quiet    = op[51];
        end else begin
            dec_in.nan_box  = (op[63:32] != 32'hFFFF_FFFF);
            dec_in.sign     = op[31];
            dec_in.exp_max  = &op[30:23];
            dec_in.exp_zero = ~|op[30:23];
            dec_in.man_zero = ~|op[22:0];
            dec_in.quiet    = op[22];
        end
    end

    function automatic logic [9:0] encode(input dec_t d);
        logic [9:0] c;
        c = '0;
        if (d.nan_box || (d.exp_max && d.quiet))
            c[9] = 1'b1;
        else if (d.exp_max && !d.man_zero)
            c[8] = 1'b1;
        else if (d.exp_max)
            c[d.sign ? 0 : 7] = 1'b1;
        else if (d.exp_zero && d.man_zero)
            c[d.sign ? 3 : 4] = 1'b1;
        else if (d.exp_zero)
            c[d.sign ? 2 : 5] = 1'b1;
        else
            c[d.sign ? 1 : 6] = 1'b1;
        return c;
    endfunction

    assign adv_out = o_valid && i_ready;
    assign accept  = i_valid && o_ready;

    generate
        if (PIPE_STAGES == 2) begin : g_two
            logic             v1, v2, load2;
            dec_t             d1;
            logic [TAG_W-1:0] t1, t2;
            logic [9:0]       c2;

            // Stage 2 frees up when empty or draining; stage 1 may refill in that same cycle.
            assign load2   = !v2 || adv_out;
            assign o_ready = (!v1 || load2) && !i_flush;
            assign o_valid = v2;
            assign cls_q   = c2;
            assign tag_q   = t2;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    v1 <= 1'b0;
                    v2 <= 1'b0;
                    d1 <= '0;
                    t1 <= '0;
                    c2 <= '0;
                    t2 <= '0;
                end else if (i_flush) begin
                    v1 <= 1'b0;
                    v2 <= 1'b0;
                end else begin
                    if (load2) begin
                        v2 <= v1;
                        if (v1) begin
                            c2 <= encode(d1);
                            t2 <= t1;
                        end
                    end
                    if (!v1 || load2) begin
                        v1 <= accept;
                        if (accept) begin
                            d1 <= dec_in;
                            t1 <= i_tag;
                        end
                    end
                end
            end
        end else begin : g_one
            logic             v1, load1;
            logic [TAG_W-1:0] t1;
            logic [9:0]       c1;

            assign load1   = !v1 || adv_out;
            assign o_ready = load1 && !i_flush;
            assign o_valid = v1;
            assign cls_q   = c1;
            assign tag_q   = t1;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    v1 <= 1'b0;
                    c1 <= '0;
                    t1 <= '0;
                end else if (i_flush) begin
                    v1 <= 1'b0;
                end else if (load1) begin
                    v1 <= accept;
                    if (accept) begin
                        c1 <= encode(dec_in);
                        t1 <= i_tag;
                    end
                end
            end
        end
    endgenerate

    assign o_rd  = {{(XLEN-10){1'b0}}, cls_q};
    assign o_tag = tag_q;

endmodule

// File: doc/fclass_pipe.md
Name: fclass_pipe

Overview:
Parametrised, pipelined floating-point classifier implementing RISC-V FCLASS.S/FCLASS.D semantics for the FP execute path. Accepts one operand per cycle over a valid/ready handshake and supports single and, when FLEN=64, double precision, with a NaN-boxing check on single operands. Carries a destination tag alongside the data and returns a one-hot 10-bit class, zero-extended to XLEN, after a fixed pipeline latency.

Parameters:
FLEN, 32, FP register width; legal values 32 or 64.
XLEN, 32, result width; class occupies bits [9:0], and bits [XLEN-1:10] are 0.
PIPE_STAGES, 2, register stages, legal 1 or 2. With 2: stage 1 decodes the fields, stage 2 encodes the one-hot result.
TAG_W, 5, width of the passthrough tag (rd index).

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst  input  1  synchronous active-high reset.
i_flush  input  1  synchronous pipeline kill.
i_valid  input  1  operand valid.
o_ready  output  1  block can accept an operand this cycle.
i_rs1_f  input  FLEN  FP operand.
i_fmt  input  1  0 = single, 1 = double. Ignored (treated as 0) when FLEN=32.
i_tag  input  TAG_W  destination tag.
o_valid  output  1  result valid.
i_ready  input  1  consumer accepts the result.
o_rd  output  XLEN  class result.
o_tag  output  TAG_W  tag of the result.

Behaviour:
- Reset (i_rst=1 at an edge): all stage valid bits are cleared. o_valid=0, o_rd=0, o_tag=0. In-flight operands are dropped.
- Transfers: input accepted when i_valid && o_ready. Output consumed when o_valid && i_ready.
- Stage advance: stage k loads when stage k is empty, or when its content moves to stage k+1 (or out) in the same cycle. o_ready = !v1 || (stage-1 content advances) && !i_flush. The ready path is combinational through the stages; no skid buffer.
- Latency and throughput: result is presented exactly PIPE_STAGES cycles after acceptance when not stalled. Throughput is 1 result per cycle under continuous i_ready.
- Stall: when o_valid && !i_ready, o_rd and o_tag hold stable and every full stage holds. Results leave in order with no loss or duplication.
- Flush (i_flush=1 at an edge): all stage valid bits are cleared and o_ready=0 that cycle, so the input is not accepted. Flush has priority over stall and accept. Reset has priority over flush.
- Field selection:
  - Single: sign=op[31], exp=op[30:23] (max 8'hFF), man=op[22:0], quiet bit man[22].
  - Double: sign=op[63], exp=op[62:52] (max 11'h7FF), man=op[51:0], quiet bit man[51].
- NaN-box rule (FLEN=64, fmt=S): if op[63:32] != 32'hFFFFFFFF, the operand is the canonical qNaN and the class is bit 9.
- Class bit (exactly one set per result):
  - bit 0: -inf.
  - bit 1: -normal.
  - bit 2: -subnormal.
  - bit 3: -0.
  - bit 4: +0.
  - bit 5: +subnormal.
  - bit 6: +normal.
  - bit 7: +inf.
  - bit 8: sNaN (exp max, man!=0, quiet bit 0).
  - bit 9: qNaN (exp max, quiet bit 1).
  - The NaN sign is ignored.
  - zero: exp=0, man=0. subnormal: exp=0, man!=0. inf: exp max, man=0. normal: all other encodings.
- Invariant: o_rd is one-hot on every cycle o_valid=1, and 0 after reset.

Test Plan:
- Reset mid-operation, FLEN=32: 2 operands in flight, then i_rst for 1 cycle -> o_valid=0, o_rd=0 the next cycle, and no stale result appears afterwards.
- Single streaming, FLEN=32, i_ready=1, back-to-back operands 0xFF800000, 0x7FC00000, 0x7F800001, 0x80000000, 0x00000001, 0x3F800000:
  - o_rd = 0x001, 0x200, 0x100, 0x008, 0x020, 0x040 in order.
  - Each result appears exactly 2 cycles after its acceptance.
- Double and NaN-box, FLEN=64:
  - fmt=D 0x0010000000000000 -> 0x040.
  - fmt=D 0x000FFFFFFFFFFFFF -> 0x020.
  - fmt=D 0xFFF0000000000000 -> 0x001.
  - fmt=S 0x000000003F800000 -> 0x200 (unboxed).
  - fmt=S 0xFFFFFFFF80000000 -> 0x008.
- Backpressure: 4 tagged operands (tags 1..4) with i_ready held 0 for 5 cycles -> o_ready drops to 0 after the pipeline fills, o_rd/o_tag stay stable, and releasing i_ready delivers tags 1,2,3,4 in consecutive cycles.
- Flush: i_flush asserted while 2 operands are in flight and i_valid=1 -> that input is not accepted, o_valid=0 the next cycle, and the next accepted operand returns normally after 2 cycles.
- PIPE_STAGES=1: operand 0x7F800000 -> o_rd=0x080 exactly 1 cycle after acceptance.
